// File: rtl/mpp_seq_pkg.sv
// +------------------------------------------------------------------------+
// | mpp_seq_pkg: shared encodings for the micro_sequencer control FSM.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package mpp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;

  // Next-address field of a microword.
  localparam logic [1:0] SEQ_NEXT   = 2'b00;
  localparam logic [1:0] SEQ_BRANCH = 2'b01;
  localparam logic [1:0] SEQ_END    = 2'b10;
  localparam logic [1:0] SEQ_RSVD   = 2'b11;

  // Branch condition select.
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_CARRY  = 2'b10;
  localparam logic [1:0] COND_NEG    = 2'b11;

  // Bit positions inside the {neg, carry, zero} flags bus.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;

endpackage : mpp_seq_pkg

`default_nettype wire

// File: rtl/micro_sequencer.sv
// +------------------------------------------------------------------------+
// | micro_sequencer: opcode fetch/decode/execute sequencer driving a       |
// | microcode control-store address with branch, end and watchdog logic.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module micro_sequencer
  import mpp_seq_pkg::*;
#(
  parameter int UPC_W      = 8,
  parameter int OP_W       = 4,
  parameter int WDOG_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OP_W-1:0]  instr,
  output logic             instr_ready,
  output logic             dec_en,
  output logic [OP_W-1:0]  dec_addr,
  input  logic [UPC_W-1:0] dec_data,
  input  logic [1:0]       seq_op,
  input  logic [UPC_W-1:0] seq_target,
  input  logic [1:0]       cond_sel,
  input  logic [2:0]       flags,
  output logic [UPC_W-1:0] upc,
  output logic             ucode_valid,
  output logic             err
);

  localparam int CNT_W = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(WDOG_LIMIT - 1);

  state_t           state;
  logic [OP_W-1:0]  ir;
  logic [CNT_W-1:0] step;

  logic cond_met;
  logic upc_last;
  logic wdog_hit;

  always_comb begin
    cond_met = 1'b0;
    case (cond_sel)
      COND_ALWAYS: cond_met = 1'b1;
      COND_ZERO:   cond_met = flags[FLAG_ZERO];
      COND_CARRY:  cond_met = flags[FLAG_CARRY];
      COND_NEG:    cond_met = flags[FLAG_NEG];
      default:     cond_met = 1'b0;
    endcase
  end

  assign upc_last = &upc;
  assign wdog_hit = (step == STEP_LAST);

  // Handshake outputs follow the state only, forced low while reset is held.
  assign instr_ready = rst_n && (state == ST_IDLE);
  assign dec_en      = rst_n && (state == ST_DECODE);
  assign ucode_valid = rst_n && (state == ST_EXEC);
  assign dec_addr    = ir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ir    <= '0;
      upc   <= '0;
      step  <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          upc   <= dec_data;
          step  <= '0;
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          // Watchdog wins over whatever the microword asks for.
          if (wdog_hit) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            step <= step + CNT_W'(1);
            case (seq_op)
              SEQ_NEXT, SEQ_BRANCH: begin
                if (seq_op == SEQ_BRANCH && cond_met) begin
                  upc <= seq_target;
                end else if (upc_last) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
                end else begin
                  upc <= upc + UPC_W'(1);
                end
              end
              SEQ_END: begin
                state <= ST_IDLE;
              end
              default: begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end
            endcase
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : micro_sequencer

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// +------------------------------------------------------------------------+
// | tb_micro_sequencer: directed self-checking bench for micro_sequencer.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_micro_sequencer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] instr;
  logic       instr_ready;
  logic       dec_en;
  logic [3:0] dec_addr;
  logic [7:0] dec_data;
  logic [1:0] seq_op;
  logic [7:0] seq_target;
  logic [1:0] cond_sel;
  logic [2:0] flags;
  logic [7:0] upc;
  logic       ucode_valid;
  logic       err;

  int tests;
  int fails;

  micro_sequencer #(
    .UPC_W      (8),
    .OP_W       (4),
    .WDOG_LIMIT (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .dec_en      (dec_en),
    .dec_addr    (dec_addr),
    .dec_data    (dec_data),
    .seq_op      (seq_op),
    .seq_target  (seq_target),
    .cond_sel    (cond_sel),
    .flags       (flags),
    .upc         (upc),
    .ucode_valid (ucode_valid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer an opcode, pass through DECODE, and stop at the first EXEC cycle.
  task automatic issue(input logic [3:0] op, input logic [7:0] start);
    instr_valid = 1'b1;
    instr       = op;
    dec_data    = start;
    tick();
    instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    dec_data = '0;
    seq_op = 2'b00;
    seq_target = '0;
    cond_sel = 2'b00;
    flags = 3'b000;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_uvalid", 32'(ucode_valid), 32'd0);
    check("rst_dec_en", 32'(dec_en), 32'd0);
    check("rst_upc", 32'(upc), 32'h00);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dec_addr", 32'(dec_addr), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 32'(instr_ready), 32'd1);

    // Opcode 0 -> start 03, NEXT, NEXT, END
    instr_valid = 1'b1;
    instr = 4'd0;
    dec_data = 8'h03;
    seq_op = 2'b00;
    tick();
    check("dec_en", 32'(dec_en), 32'd1);
    check("dec_ready", 32'(instr_ready), 32'd0);
    check("dec_uvalid", 32'(ucode_valid), 32'd0);
    check("dec_addr", 32'(dec_addr), 32'd0);
    instr_valid = 1'b0;
    tick();
    check("exec_upc0", 32'(upc), 32'h03);
    check("exec_uvalid", 32'(ucode_valid), 32'd1);
    check("exec_dec_en", 32'(dec_en), 32'd0);
    tick();
    check("exec_upc1", 32'(upc), 32'h04);
    tick();
    check("exec_upc2", 32'(upc), 32'h05);
    check("exec_uvalid2", 32'(ucode_valid), 32'd1);
    seq_op = 2'b10;
    tick();
    check("end_ready", 32'(instr_ready), 32'd1);
    check("end_uvalid", 32'(ucode_valid), 32'd0);
    check("end_upc_hold", 32'(upc), 32'h05);
    check("end_err", 32'(err), 32'd0);

    // Branch on zero, taken
    seq_op = 2'b00;
    issue(4'd5, 8'h20);
    check("br_start", 32'(upc), 32'h20);
    seq_op = 2'b01;
    cond_sel = 2'b01;
    seq_target = 8'h40;
    flags = 3'b001;
    tick();
    check("br_zero_taken", 32'(upc), 32'h40);
    seq_op = 2'b10;
    tick();

    // Branch on zero, not taken, then carry and neg taken
    seq_op = 2'b00;
    issue(4'd5, 8'h20);
    seq_op = 2'b01;
    cond_sel = 2'b01;
    seq_target = 8'h40;
    flags = 3'b000;
    tick();
    check("br_zero_fall", 32'(upc), 32'h21);
    cond_sel = 2'b10;
    seq_target = 8'h80;
    flags = 3'b010;
    tick();
    check("br_carry_taken", 32'(upc), 32'h80);
    cond_sel = 2'b11;
    seq_target = 8'h90;
    flags = 3'b011;
    tick();
    check("br_neg_fall", 32'(upc), 32'h81);
    flags = 3'b100;
    tick();
    check("br_neg_taken", 32'(upc), 32'h90);
    seq_op = 2'b10;
    tick();
    check("br_end_ready", 32'(instr_ready), 32'd1);
    flags = 3'b000;
    cond_sel = 2'b00;

    // Watchdog: NEXT forever from 03
    seq_op = 2'b00;
    issue(4'd3, 8'h03);
    repeat (63) tick();
    check("wdog_pre_upc", 32'(upc), 32'h42);
    check("wdog_pre_uvalid", 32'(ucode_valid), 32'd1);
    check("wdog_pre_err", 32'(err), 32'd0);
    tick();
    check("wdog_err", 32'(err), 32'd1);
    check("wdog_idle", 32'(instr_ready), 32'd1);
    check("wdog_uvalid", 32'(ucode_valid), 32'd0);
    tick();
    check("wdog_err_1cyc", 32'(err), 32'd0);

    // upc FF with NEXT: error, no wrap
    issue(4'd4, 8'hFF);
    check("ovf_start", 32'(upc), 32'hFF);
    tick();
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_upc", 32'(upc), 32'hFF);
    check("ovf_idle", 32'(instr_ready), 32'd1);
    tick();
    check("ovf_err_1cyc", 32'(err), 32'd0);

    // Reserved op
    issue(4'd6, 8'h10);
    seq_op = 2'b11;
    tick();
    check("rsvd_err", 32'(err), 32'd1);
    check("rsvd_idle", 32'(instr_ready), 32'd1);
    check("rsvd_uvalid", 32'(ucode_valid), 32'd0);
    seq_op = 2'b00;
    tick();

    // Reset mid-EXEC aborts without err
    issue(4'd9, 8'h30);
    tick();
    check("mid_upc", 32'(upc), 32'h31);
    rst_n = 1'b0;
    #1;
    check("rstlow_uvalid", 32'(ucode_valid), 32'd0);
    tick();
    check("abort_upc", 32'(upc), 32'h00);
    check("abort_err", 32'(err), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd0);
    check("abort_dec_addr", 32'(dec_addr), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    issue(4'd7, 8'h50);
    check("post_rst_upc", 32'(upc), 32'h50);
    check("post_rst_addr", 32'(dec_addr), 32'd7);
    seq_op = 2'b10;
    tick();

    // Back-to-back held valid: opcodes 1 then 2
    instr_valid = 1'b1;
    instr = 4'd1;
    dec_data = 8'h10;
    tick();
    check("b2b_dec1", 32'(dec_addr), 32'd1);
    instr = 4'd2;
    tick();
    check("b2b_exec1_upc", 32'(upc), 32'h10);
    check("b2b_ir_kept", 32'(dec_addr), 32'd1);
    check("b2b_exec_ready", 32'(instr_ready), 32'd0);
    dec_data = 8'h60;
    tick();
    check("b2b_dead_ready", 32'(instr_ready), 32'd1);
    check("b2b_dead_dec_en", 32'(dec_en), 32'd0);
    tick();
    check("b2b_dec2_en", 32'(dec_en), 32'd1);
    check("b2b_dec2", 32'(dec_addr), 32'd2);
    instr_valid = 1'b0;
    tick();
    check("b2b_exec2_upc", 32'(upc), 32'h60);
    tick();
    check("b2b_end2_ready", 32'(instr_ready), 32'd1);
    tick();
    check("b2b_once", 32'(instr_ready), 32'd1);
    check("b2b_once_dec_en", 32'(dec_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_micro_sequencer

`default_nettype wire

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter UPC_W, default 8, micro-PC width; SHALL equal the decode table data width.
REQ-002 Parameter OP_W, default 4, opcode width; SHALL equal the decode table address width.
REQ-003 Parameter WDOG_LIMIT, default 64, maximum EXEC cycles per instruction.
REQ-004 One clock; reset is synchronous and active-low; ports are clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 instr_valid  in  1  opcode offered.
REQ-008 instr  in  OP_W  opcode.
REQ-009 instr_ready  out  1  sequencer accepts an opcode.
REQ-010 dec_en  out  1  enable to the decode table.
REQ-011 dec_addr  out  OP_W  decode table address (latched opcode).
REQ-012 dec_data  in  UPC_W  microprogram start address from the decode table.
REQ-013 seq_op  in  2  next-address field of the current microword: 00 NEXT, 01 BRANCH, 10 END, 11 reserved.
REQ-014 seq_target  in  UPC_W  branch target of the current microword.
REQ-015 cond_sel  in  2  branch condition: 00 always, 01 zero, 10 carry, 11 neg.
REQ-016 flags  in  3  {neg, carry, zero} datapath status.
REQ-017 upc  out  UPC_W  control-store address.
REQ-018 ucode_valid  out  1  upc addresses a live microword.
REQ-019 err  out  1  one-cycle error pulse.

Function
REQ-020 FSM states SHALL be IDLE, DECODE and EXEC.
REQ-021 IDLE: instr_ready=1; on instr_valid&&instr_ready, latch instr into IR, go to DECODE; otherwise stay in IDLE.
REQ-022 DECODE: dec_en=1, dec_addr=IR, lasting exactly one cycle; at its closing edge, upc<=dec_data, step counter<=0, go to EXEC.
REQ-023 dec_addr SHALL hold IR in all states; dec_en SHALL be 1 only in DECODE.
REQ-024 EXEC: ucode_valid=1; at each edge, evaluate seq_op against the current upc.
REQ-025 NEXT: upc<=upc+1; if upc is all ones, assert err and go to IDLE (no wrap to 0).
REQ-026 BRANCH: if the selected condition is true, upc<=seq_target; otherwise, apply the NEXT rule.
REQ-027 END: go to IDLE; upc holds; instr_ready=1 on the following cycle.
REQ-028 Reserved op (11): assert err and go to IDLE.
REQ-029 Step counter SHALL count EXEC cycles; when it reaches WDOG_LIMIT-1 without END, assert err and go to IDLE; the watchdog SHALL take priority over seq_op.
REQ-030 Latency: acceptance to first ucode_valid SHALL be 2 cycles (DECODE, then EXEC).
REQ-031 instr_ready SHALL be 0 in DECODE and EXEC; instr_valid held high during those states SHALL be ignored and accepted on return to IDLE.
REQ-032 After END, an opcode already valid SHALL be accepted in the first IDLE cycle (one dead cycle between instructions).
REQ-033 err SHALL last exactly one cycle, coincident with the edge entering IDLE.
REQ-034 instr_ready, ucode_valid and dec_en SHALL be decoded from the state register only.

Reset
REQ-035 While rst_n=0 at a clock edge: state<=IDLE, IR<=0, upc<=0, counter<=0, err<=0.
REQ-036 While rst_n=0, instr_ready, ucode_valid and dec_en SHALL be 0; rst_n low mid-EXEC SHALL abort the instruction without an err pulse.

Structure
REQ-037 Package mpp_seq_pkg SHALL hold the state enum, the seq_op encodings and the cond_sel encodings.
REQ-038 The block SHALL be a single flat module with no sub-module; the condition mux is inline.

Verification
REQ-039 Opcode 0 accepted, decode table returns 8'h03; seq_op NEXT, NEXT, END -> upc 03,04,05, ucode_valid for 3 cycles, then instr_ready=1.
REQ-040 Microword at upc=8'h20: BRANCH, cond_sel=01, target 8'h40, zero=1 -> next upc 8'h40; same case with zero=0 -> next upc 8'h21.
REQ-041 seq_op held NEXT from start address 8'h03, WDOG_LIMIT=64 -> err pulse after the 64th EXEC cycle, state returns to IDLE.
REQ-042 upc=8'hFF with NEXT -> err, IDLE; upc never becomes 8'h00. seq_op=11 -> err, IDLE.
REQ-043 rst_n driven low for 1 cycle during EXEC -> next cycle all outputs at reset values, err=0, then the next opcode is accepted normally.
REQ-044 instr_valid held high with opcodes 1 then 2 -> each accepted exactly once, with one IDLE cycle between END and the next acceptance.
